// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches to imem,
// buffers returned words with their PCs and flushes on execute redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    logic        rst_n_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q [DEPTH];
    logic [31:0] bpc_q  [DEPTH];
    ptr_t        head_q, tail_q;
    cnt_t        occ_q;
    logic [31:0] pf_q   [DEPTH];
    ptr_t        pf_head_q, pf_tail_q;
    cnt_t        out_q, drop_q;

    logic        credit, fire, deq, keep;
    logic [CW:0] used;
    cnt_t        out_d, occ_d;

    always_comb begin
        used   = {1'b0, out_q} + {1'b0, occ_q};
        credit = used < (CW+1)'(DEPTH);
        imem_req_valid = rst_n_q & ~redirect_valid & credit;
        fire   = imem_req_valid & imem_req_ready;
        id_valid = occ_q != '0;
        deq    = id_valid & id_ready;
        // A word is kept only if it is not owed to an earlier redirect and
        // no redirect is flushing the buffer this cycle.
        keep   = imem_rsp_valid & (drop_q == '0) & ~redirect_valid;
        out_d  = out_q + cnt_t'(fire) - cnt_t'(imem_rsp_valid);
        occ_d  = occ_q + cnt_t'(keep) - cnt_t'(deq);
        imem_req_addr = pc_q;
        id_inst = id_valid ? inst_q[head_q] : NOP_INST;
        id_pc   = id_valid ? bpc_q[head_q]  : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rst_n_q   <= 1'b0;
            pc_q      <= RESET_PC;
            head_q    <= '0;
            tail_q    <= '0;
            occ_q     <= '0;
            pf_head_q <= '0;
            pf_tail_q <= '0;
            out_q     <= '0;
            drop_q    <= '0;
        end else begin
            rst_n_q <= 1'b1;
            if (redirect_valid) begin
                // Everything still in flight becomes a word to throw away.
                pc_q      <= redirect_pc & ~32'h3;
                head_q    <= '0;
                tail_q    <= '0;
                occ_q     <= '0;
                pf_head_q <= '0;
                pf_tail_q <= '0;
                out_q     <= out_q - cnt_t'(imem_rsp_valid);
                drop_q    <= out_q - cnt_t'(imem_rsp_valid);
            end else begin
                if (fire) begin
                    pc_q             <= pc_q + 32'd4;
                    pf_q[pf_tail_q]  <= pc_q;
                    pf_tail_q        <= ptr_inc(pf_tail_q);
                end
                if (imem_rsp_valid) begin
                    if (drop_q != '0) begin
                        drop_q <= drop_q - cnt_t'(1);
                    end else begin
                        inst_q[tail_q] <= imem_rsp_data;
                        bpc_q[tail_q]  <= pf_q[pf_head_q];
                        tail_q         <= ptr_inc(tail_q);
                        pf_head_q      <= ptr_inc(pf_head_q);
                    end
                end
                if (deq)
                    head_q <= ptr_inc(head_q);
                occ_q <= occ_d;
                out_q <= out_d;
            end
        end
    end
endmodule
